vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Raster timing generator for the 640x480@60 VGA output path.
- Divides the 50 MHz system clock to a pixel-clock enable and runs horizontal and vertical counters.
- Drives the xloc/yloc pixel coordinates into the display block (text/graph video memories and palette ROM).
- Produces HS/VS/BLANK_N/SYNC_N/VGA_CLK, delayed by the display's read latency so sync and colour arrive aligned at the DAC.
- Gives software a vblank status bit, a frame-start strobe and a frame counter.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- PIX_DIV, 2, system clocks per pixel; must be >=2 and even
- PIPE_DLY, 2, pixel ticks between xloc/yloc and valid colour at the display output; range 0..7

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- xloc  out  10  current pixel column sent to the display
- yloc  out  9  current pixel row sent to the display
- VGA_CLK  out  1  pixel clock to the DAC
- VGA_HS  out  1  horizontal sync, active-low, aligned to colour
- VGA_VS  out  1  vertical sync, active-low, aligned to colour
- VGA_BLANK_N  out  1  low outside the visible area, aligned to colour
- VGA_SYNC_N  out  1  tied 0 (no sync-on-green)
- vblank_o  out  1  high while the vertical counter is outside the visible lines (undelayed)
- frame_start_o  out  1  one-clk pulse at the raster wrap to (0,0)
- frame_cnt_o  out  16  completed-frame count, wraps

Behaviour:
- Derived constants: H_TOTAL = sum of the four H_* parameters = 800. V_TOTAL = sum of the four V_* parameters = 525.
- Divider:
  - div_cnt counts 0..PIX_DIV-1 and wraps.
  - pix_ce is a one-clk pulse when div_cnt == PIX_DIV-1.
  - VGA_CLK is registered; it is 1 when div_cnt >= PIX_DIV/2.
  - With PIX_DIV=2: VGA_CLK is 0,1,0,1… and pix_ce coincides with VGA_CLK high.
- Counters (advance only on pix_ce):
  - h_cnt counts 0..H_TOTAL-1.
  - On h_cnt wrap, v_cnt increments, wrapping at V_TOTAL-1 to 0.
- Coordinates (registered; update on the clk after pix_ce):
  - xloc = h_cnt when h_cnt < H_VISIBLE, else 0, so line-start data is prefetched during hblank.
  - yloc = v_cnt when v_cnt < V_VISIBLE, else 0.
- Raw timing, computed from the counters:
  - hs_raw = 0 when H_VISIBLE+H_FP <= h_cnt < H_VISIBLE+H_FP+H_SYNC, i.e. 656..751.
  - vs_raw = 0 when v_cnt is in 490..491.
  - blank_n_raw = 1 when h_cnt < 640 and v_cnt < 480.
- Alignment:
  - hs_raw, vs_raw and blank_n_raw pass through a PIPE_DLY-deep shift register clocked by pix_ce, then an output register.
  - PIPE_DLY=0 means output register only.
- vblank_o = registered (v_cnt >= V_VISIBLE), undelayed.
- frame_start_o:
  - Pulses for exactly one clk on the pix_ce where h_cnt = H_TOTAL-1 and v_cnt = V_TOTAL-1.
  - frame_cnt_o increments on the same cycle; 16'hFFFF wraps to 0.
- Reset, synchronous, overrides everything:
  - div_cnt, h_cnt, v_cnt, xloc, yloc, frame_cnt_o = 0.
  - VGA_CLK = 0, frame_start_o = 0, vblank_o = 0.
  - The delay line fills with idle values HS=1, VS=1, BLANK_N=0, so VGA_HS=1, VGA_VS=1, VGA_BLANK_N=0.
  - Mid-frame reset restarts at (0,0) on the next pix_ce cycle with no frame_start_o pulse. The first pulse comes after a full frame.
- No sync glitches: HS/VS change only on the clk following pix_ce.

Decomposition:
- Shared package vga_pkg holds:
  - the 640x480@60 timing constants (H_*/V_*, H_TOTAL, V_TOTAL)
  - coordinate width constants (X_W=10, Y_W=9)
- One sub-module, vga_sig_delay: a parameterised PIPE_DLY-deep, 3-bit shift register with enable and a reset value.

Test Plan:
- Reset held 3 clks, then released → VGA_HS=1, VGA_VS=1, VGA_BLANK_N=0, xloc=0, yloc=0. First pix_ce is the 2nd clk after release, with PIX_DIV=2.
- One line, checking each pix_ce → xloc steps 0..639, then reads 0 for h_cnt 640..799. VGA_HS is low for exactly 96 pixel ticks, starting PIPE_DLY ticks after h_cnt=656. The line is 1600 clks.
- One full frame → VGA_VS is low for 2 lines (1600 pixel ticks), starting at line 490 plus PIPE_DLY. vblank_o is high from line 480 through 524. VGA_BLANK_N is high for 307200 ticks per frame.
- Frame boundary → frame_start_o pulses once every 840000 clks. frame_cnt_o goes 0→1→2; with the counter force-loaded to 16'hFFFF, the next frame gives 0.
- Reset asserted at v_cnt=300, h_cnt=400 → next pix_ce has xloc=0, yloc=0, syncs idle, frame_cnt_o=0, and no frame_start_o until 840000 clks later.
- PIPE_DLY=0 and PIPE_DLY=5 builds → the hsync falling edge is 1 and 6 pixel ticks after h_cnt reaches 656, respectively.

Source files
------------

// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vga_pkg
//  Description : Shared 640x480@60 raster timing constants, coordinate widths
//                and the sync bundle carried down the alignment delay line.
//  Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

    // Horizontal timing, in pixels
    localparam int H_VISIBLE = 640;
    localparam int H_FP      = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BP      = 48;
    localparam int H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;

    // Vertical timing, in lines
    localparam int V_VISIBLE = 480;
    localparam int V_FP      = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BP      = 33;
    localparam int V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;

    // Coordinate widths towards the display block
    localparam int X_W = 10;
    localparam int Y_W = 9;

    // Sync/blank bundle; bit order is {hs, vs, blank_n}
    typedef struct packed {
        logic hs;
        logic vs;
        logic blank_n;
    } sync_t;

    // Value shown on the DAC side while nothing has been timed yet
    localparam sync_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, blank_n: 1'b0};

    // Sum of the four segments of one timing axis
    function automatic int axis_total(input int vis, input int fp,
                                      input int sync, input int bp);
        return vis + fp + sync + bp;
    endfunction

endpackage : vga_pkg
`default_nettype wire

// File: rtl/vga_sig_delay.sv
`default_nettype none
// ============================================================================
//  Module      : vga_sig_delay
//  Description : DEPTH-deep, 3-bit shift register advancing on i_en. DEPTH=0
//                is a pure wire. Every stage loads RST_VAL on reset.
//  Ports       : clk, rst    - clock, synchronous active-high reset
//                i_en        - shift enable (pixel tick)
//                i_d / o_q   - 3-bit data in / delayed data out
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_sig_delay #(
    parameter int         DEPTH   = 2,
    parameter logic [2:0] RST_VAL = 3'b000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_en,
    input  logic [2:0] i_d,
    output logic [2:0] o_q
);

    generate
        if (DEPTH == 0) begin : g_bypass
            assign o_q = i_d;
        end else begin : g_shift
            logic [DEPTH-1:0][2:0] r_sr;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_sr <= {DEPTH{RST_VAL}};
                end else if (i_en) begin
                    r_sr[0] <= i_d;
                    for (int i = 1; i < DEPTH; i++) begin
                        r_sr[i] <= r_sr[i-1];
                    end
                end
            end

            assign o_q = r_sr[DEPTH-1];
        end
    endgenerate

endmodule : vga_sig_delay
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_gen
//  Description : VGA raster timing generator. Divides clk into a pixel tick,
//                runs the h/v raster counters, drives pixel coordinates into
//                the display block and produces DAC syncs delayed to line up
//                with the display's colour read latency.
//  Ports       : clk, rst        - system clock, synchronous active-high reset
//                xloc, yloc      - pixel coordinate (0 outside visible area)
//                VGA_CLK         - pixel clock to the DAC
//                VGA_HS, VGA_VS  - active-low syncs, aligned to colour
//                VGA_BLANK_N     - low outside the visible area, aligned
//                VGA_SYNC_N      - constant 0
//                vblank_o        - vertical counter outside visible lines
//                frame_start_o   - one-clk pulse at the raster wrap to (0,0)
//                frame_cnt_o     - completed-frame count, wraps
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_VISIBLE = vga_pkg::H_VISIBLE,
    parameter int H_FP      = vga_pkg::H_FP,
    parameter int H_SYNC    = vga_pkg::H_SYNC,
    parameter int H_BP      = vga_pkg::H_BP,
    parameter int V_VISIBLE = vga_pkg::V_VISIBLE,
    parameter int V_FP      = vga_pkg::V_FP,
    parameter int V_SYNC    = vga_pkg::V_SYNC,
    parameter int V_BP      = vga_pkg::V_BP,
    parameter int PIX_DIV   = 2,
    parameter int PIPE_DLY  = 2
) (
    input  logic           clk,
    input  logic           rst,
    output logic [X_W-1:0] xloc,
    output logic [Y_W-1:0] yloc,
    output logic           VGA_CLK,
    output logic           VGA_HS,
    output logic           VGA_VS,
    output logic           VGA_BLANK_N,
    output logic           VGA_SYNC_N,
    output logic           vblank_o,
    output logic           frame_start_o,
    output logic [15:0]    frame_cnt_o
);

    localparam int H_TOT = axis_total(H_VISIBLE, H_FP, H_SYNC, H_BP);
    localparam int V_TOT = axis_total(V_VISIBLE, V_FP, V_SYNC, V_BP);
    localparam int DIV_W = $clog2(PIX_DIV);
    localparam int HC_W  = $clog2(H_TOT);
    localparam int VC_W  = $clog2(V_TOT);

    localparam logic [DIV_W-1:0] C_DIV_LAST = DIV_W'(PIX_DIV - 1);
    localparam logic [DIV_W-1:0] C_DIV_HALF = DIV_W'(PIX_DIV / 2);
    localparam logic [HC_W-1:0]  C_H_LAST   = HC_W'(H_TOT - 1);
    localparam logic [HC_W-1:0]  C_H_VIS    = HC_W'(H_VISIBLE);
    localparam logic [HC_W-1:0]  C_HS_FIRST = HC_W'(H_VISIBLE + H_FP);
    localparam logic [HC_W-1:0]  C_HS_LAST  = HC_W'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam logic [VC_W-1:0]  C_V_LAST   = VC_W'(V_TOT - 1);
    localparam logic [VC_W-1:0]  C_V_VIS    = VC_W'(V_VISIBLE);
    localparam logic [VC_W-1:0]  C_VS_FIRST = VC_W'(V_VISIBLE + V_FP);
    localparam logic [VC_W-1:0]  C_VS_LAST  = VC_W'(V_VISIBLE + V_FP + V_SYNC - 1);

    // ------------------------------------------------------------------
    // Pixel-clock divider
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] r_div_cnt;
    logic [DIV_W-1:0] w_div_nxt;
    logic             w_pix_ce;
    logic             r_vga_clk;

    assign w_pix_ce  = (r_div_cnt == C_DIV_LAST);
    assign w_div_nxt = w_pix_ce ? '0 : r_div_cnt + 1'b1;

    // VGA_CLK is registered from the next divider value so it tracks the
    // current divider phase exactly: high in the second half of each pixel,
    // which puts the pix_ce cycle inside the high phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_cnt <= '0;
            r_vga_clk <= 1'b0;
        end else begin
            r_div_cnt <= w_div_nxt;
            r_vga_clk <= (w_div_nxt >= C_DIV_HALF);
        end
    end

    // ------------------------------------------------------------------
    // Raster counters, coordinates, vblank and frame bookkeeping
    // ------------------------------------------------------------------
    logic [HC_W-1:0] r_h_cnt;
    logic [VC_W-1:0] r_v_cnt;
    logic [HC_W-1:0] w_h_nxt;
    logic [VC_W-1:0] w_v_nxt;
    logic            w_h_last;
    logic            w_v_last;
    logic [X_W-1:0]  r_xloc;
    logic [Y_W-1:0]  r_yloc;
    logic            r_vblank;
    logic            r_frame_start;
    logic [15:0]     r_frame_cnt;

    assign w_h_last = (r_h_cnt == C_H_LAST);
    assign w_v_last = (r_v_cnt == C_V_LAST);
    assign w_h_nxt  = w_h_last ? '0 : r_h_cnt + 1'b1;
    assign w_v_nxt  = !w_h_last ? r_v_cnt : (w_v_last ? '0 : r_v_cnt + 1'b1);

    // Coordinates are taken from the counter value that was current during
    // the pixel tick, i.e. one tick behind the counters. The sync path has
    // the same one-tick output register, so colour and sync stay aligned.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_h_cnt       <= '0;
            r_v_cnt       <= '0;
            r_xloc        <= '0;
            r_yloc        <= '0;
            r_vblank      <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_cnt   <= '0;
        end else begin
            r_frame_start <= w_pix_ce && w_h_last && w_v_last;
            if (w_pix_ce) begin
                r_h_cnt  <= w_h_nxt;
                r_v_cnt  <= w_v_nxt;
                // Zero outside the visible area so the first pixel of the
                // next line is already being fetched during hblank.
                r_xloc   <= (r_h_cnt < C_H_VIS) ? X_W'(r_h_cnt) : '0;
                r_yloc   <= (r_v_cnt < C_V_VIS) ? Y_W'(r_v_cnt) : '0;
                r_vblank <= (w_v_nxt >= C_V_VIS);
                if (w_h_last && w_v_last) begin
                    r_frame_cnt <= r_frame_cnt + 16'd1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Raw sync/blank, colour-latency delay line, output register
    // ------------------------------------------------------------------
    sync_t w_raw;
    sync_t w_dly;
    sync_t r_out;

    assign w_raw.hs      = !((r_h_cnt >= C_HS_FIRST) && (r_h_cnt <= C_HS_LAST));
    assign w_raw.vs      = !((r_v_cnt >= C_VS_FIRST) && (r_v_cnt <= C_VS_LAST));
    assign w_raw.blank_n = (r_h_cnt < C_H_VIS) && (r_v_cnt < C_V_VIS);

    vga_sig_delay #(
        .DEPTH   (PIPE_DLY),
        .RST_VAL (SYNC_IDLE)
    ) u_sig_delay (
        .clk  (clk),
        .rst  (rst),
        .i_en (w_pix_ce),
        .i_d  (w_raw),
        .o_q  (w_dly)
    );

    // Updating only on the pixel tick keeps every sync transition on the
    // clk right after pix_ce, never mid-pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out <= SYNC_IDLE;
        end else if (w_pix_ce) begin
            r_out <= w_dly;
        end
    end

    assign xloc          = r_xloc;
    assign yloc          = r_yloc;
    assign VGA_CLK       = r_vga_clk;
    assign VGA_HS        = r_out.hs;
    assign VGA_VS        = r_out.vs;
    assign VGA_BLANK_N   = r_out.blank_n;
    assign VGA_SYNC_N    = 1'b0;
    assign vblank_o      = r_vblank;
    assign frame_start_o = r_frame_start;
    assign frame_cnt_o   = r_frame_cnt;

endmodule : vga_timing_gen
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_timing_gen
//  Description : Bench for vga_timing_gen. Three instances (two reduced
//                rasters with different dividers/delays, one full 640x480)
//                are checked every clk against an arithmetic model that
//                derives all outputs from the number of clocks since reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

    typedef struct packed {
        logic [9:0]  x;
        logic [8:0]  y;
        logic        vclk;
        logic        hs;
        logic        vs;
        logic        bn;
        logic        vbl;
        logic        fs;
        logic [15:0] fc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    logic rst_c = 1'b1;
    logic chk   = 1'b0;

    int n_a = 0;
    int n_b = 0;
    int n_c = 0;
    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- DUT outputs ----------------
    logic [9:0]  x_a, x_b, x_c;
    logic [8:0]  y_a, y_b, y_c;
    logic        vclk_a, hs_a, vs_a, bn_a, sn_a, vbl_a, fs_a;
    logic        vclk_b, hs_b, vs_b, bn_b, sn_b, vbl_b, fs_b;
    logic        vclk_c, hs_c, vs_c, bn_c, sn_c, vbl_c, fs_c;
    logic [15:0] fc_a, fc_b, fc_c;

    // Reduced raster: 32 x 15, PIX_DIV 2, PIPE_DLY 2
    vga_timing_gen #(
        .H_VISIBLE(20), .H_FP(3), .H_SYNC(5), .H_BP(4),
        .V_VISIBLE(8),  .V_FP(2), .V_SYNC(2), .V_BP(3),
        .PIX_DIV(2), .PIPE_DLY(2)
    ) dut_a (
        .clk(clk), .rst(rst_a), .xloc(x_a), .yloc(y_a), .VGA_CLK(vclk_a),
        .VGA_HS(hs_a), .VGA_VS(vs_a), .VGA_BLANK_N(bn_a), .VGA_SYNC_N(sn_a),
        .vblank_o(vbl_a), .frame_start_o(fs_a), .frame_cnt_o(fc_a)
    );

    // Same raster, PIX_DIV 4, PIPE_DLY 5
    vga_timing_gen #(
        .H_VISIBLE(20), .H_FP(3), .H_SYNC(5), .H_BP(4),
        .V_VISIBLE(8),  .V_FP(2), .V_SYNC(2), .V_BP(3),
        .PIX_DIV(4), .PIPE_DLY(5)
    ) dut_b (
        .clk(clk), .rst(rst_b), .xloc(x_b), .yloc(y_b), .VGA_CLK(vclk_b),
        .VGA_HS(hs_b), .VGA_VS(vs_b), .VGA_BLANK_N(bn_b), .VGA_SYNC_N(sn_b),
        .vblank_o(vbl_b), .frame_start_o(fs_b), .frame_cnt_o(fc_b)
    );

    // Full 640x480 raster, PIPE_DLY 0
    vga_timing_gen #(
        .PIX_DIV(2), .PIPE_DLY(0)
    ) dut_c (
        .clk(clk), .rst(rst_c), .xloc(x_c), .yloc(y_c), .VGA_CLK(vclk_c),
        .VGA_HS(hs_c), .VGA_VS(vs_c), .VGA_BLANK_N(bn_c), .VGA_SYNC_N(sn_c),
        .vblank_o(vbl_c), .frame_start_o(fs_c), .frame_cnt_o(fc_c)
    );

    exp_t act_a, act_b, act_c;
    assign act_a = {x_a, y_a, vclk_a, hs_a, vs_a, bn_a, vbl_a, fs_a, fc_a};
    assign act_b = {x_b, y_b, vclk_b, hs_b, vs_b, bn_b, vbl_b, fs_b, fc_b};
    assign act_c = {x_c, y_c, vclk_c, hs_c, vs_c, bn_c, vbl_c, fs_c, fc_c};

    // ---------------- reference model ----------------
    // n = clocks since reset released. Pixel ticks so far p = n / d.
    // Coordinates show the pixel of the last tick (p-1); syncs show the
    // pixel pd ticks before that; vblank tracks the current line.
    function automatic exp_t model(input int n,
                                   input int hv, input int hf, input int hsw, input int hb,
                                   input int vv, input int vf, input int vsw, input int vb,
                                   input int d,  input int pd);
        exp_t e;
        int ht, vt, f, p, q, h, v;
        ht = hv + hf + hsw + hb;
        vt = vv + vf + vsw + vb;
        f  = ht * vt;
        p  = n / d;
        e  = '0;
        e.vclk = ((n % d) >= (d / 2));
        q = p - 1;
        if (q >= 0) begin
            h = q % ht;
            v = (q / ht) % vt;
            e.x = (h < hv) ? 10'(h) : 10'd0;
            e.y = (v < vv) ? 9'(v) : 9'd0;
        end
        e.vbl = (((p / ht) % vt) >= vv);
        q = p - 1 - pd;
        if (q >= 0) begin
            h = q % ht;
            v = (q / ht) % vt;
            e.hs = !((h >= hv + hf) && (h < hv + hf + hsw));
            e.vs = !((v >= vv + vf) && (v < vv + vf + vsw));
            e.bn = (h < hv) && (v < vv);
        end else begin
            e.hs = 1'b1;
            e.vs = 1'b1;
            e.bn = 1'b0;
        end
        e.fs = (n > 0) && ((n % (d * f)) == 0);
        e.fc = 16'((p / f) % 65536);
        return e;
    endfunction

    task automatic cmp(input string nm, input int n, input exp_t a, input exp_t e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s n=%0d got x=%0d y=%0d clk=%b hs=%b vs=%b bn=%b vbl=%b fs=%b fc=%0d want x=%0d y=%0d clk=%b hs=%b vs=%b bn=%b vbl=%b fs=%b fc=%0d",
                     nm, n, a.x, a.y, a.vclk, a.hs, a.vs, a.bn, a.vbl, a.fs, a.fc,
                     e.x, e.y, e.vclk, e.hs, e.vs, e.bn, e.vbl, e.fs, e.fc);
        end
    endtask

    task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s got %0d want %0d", nm, act, want);
        end
    endtask

    // Clocks since reset, as seen after each edge
    always @(posedge clk) begin
        n_a <= rst_a ? 0 : n_a + 1;
        n_b <= rst_b ? 0 : n_b + 1;
        n_c <= rst_c ? 0 : n_c + 1;
    end

    // Single compare process, sampling on the falling edge
    always @(negedge clk) begin
        if (chk) begin
            cmp("dut_a", n_a, act_a, model(n_a, 20, 3, 5, 4, 8, 2, 2, 3, 2, 2));
            cmp("dut_b", n_b, act_b, model(n_b, 20, 3, 5, 4, 8, 2, 2, 3, 4, 5));
            cmp("dut_c", n_c, act_c, model(n_c, 640, 16, 96, 48, 480, 10, 2, 33, 2, 0));
            lit("sync_n_a", {31'd0, sn_a}, 32'd0);
            lit("sync_n_c", {31'd0, sn_c}, 32'd0);

            // Hand-computed points that pin the model
            if (n_a == 0) begin
                lit("rst_hs_a", {31'd0, hs_a}, 32'd1);
                lit("rst_vs_a", {31'd0, vs_a}, 32'd1);
                lit("rst_bn_a", {31'd0, bn_a}, 32'd0);
                lit("rst_x_a",  {22'd0, x_a},  32'd0);
                lit("rst_fc_a", {16'd0, fc_a}, 32'd0);
            end
            if (n_a == 4)    lit("first_x_a",   {22'd0, x_a},  32'd1);
            if (n_a == 50)   lit("hs_pre_a",    {31'd0, hs_a}, 32'd1);
            if (n_a == 52)   lit("hs_fall_a",   {31'd0, hs_a}, 32'd0);
            if (n_a == 958)  lit("fs_pre_a",    {31'd0, fs_a}, 32'd0);
            if (n_a == 960)  lit("fs_a",        {31'd0, fs_a}, 32'd1);
            if (n_a == 960)  lit("fc1_a",       {16'd0, fc_a}, 32'd1);
            if (n_a == 961)  lit("fs_end_a",    {31'd0, fs_a}, 32'd0);
            if (n_a == 1920) lit("fc2_a",       {16'd0, fc_a}, 32'd2);
            if (n_b == 115)  lit("hs_pre_b",    {31'd0, hs_b}, 32'd1);
            if (n_b == 116)  lit("hs_fall_b",   {31'd0, hs_b}, 32'd0);
            if (n_c == 1280) lit("x639_c",      {22'd0, x_c},  32'd639);
            if (n_c == 1282) lit("x_hblank_c",  {22'd0, x_c},  32'd0);
            if (n_c == 1312) lit("hs_pre_c",    {31'd0, hs_c}, 32'd1);
            if (n_c == 1314) lit("hs_fall_c",   {31'd0, hs_c}, 32'd0);
            if (n_c == 1315) lit("vclk_hi_c",   {31'd0, vclk_c}, 32'd1);
            if (n_c == 1600) lit("line1_x_c",   {22'd0, x_c},  32'd0);
            if (n_c == 1602) lit("line1_y_c",   {23'd0, y_c},  32'd1);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int gap;
        int len;
        logic [2:0] sel;

        repeat (3) @(posedge clk);
        chk = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        rst_b = 1'b0;
        rst_c = 1'b0;

        // Uninterrupted run covering the first frames of the small rasters
        // and the first lines of the full raster
        repeat (4000) @(negedge clk);

        // Random mid-raster resets on random subsets of the instances
        for (int i = 0; i < 24; i++) begin
            gap = $urandom_range(100, 2400);
            repeat (gap) @(negedge clk);
            sel = 3'($urandom_range(1, 7));
            len = $urandom_range(1, 3);
            if (sel[0]) rst_a = 1'b1;
            if (sel[1]) rst_b = 1'b1;
            if (sel[2]) rst_c = 1'b1;
            repeat (len) @(negedge clk);
            rst_a = 1'b0;
            rst_b = 1'b0;
            rst_c = 1'b0;
        end

        repeat (4000) @(negedge clk);
        chk = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_vga_timing_gen
`default_nettype wire
